// File: rtl/output_deskew.sv
// Reassembles the column-skewed result streams from the bottom of the 2x2 systolic
// array into an aligned 2x2 matrix, handed off to the consumer with valid/ack.
module output_deskew #(
    parameter int ACC_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             col1_valid,
    input  logic [ACC_W-1:0] col1_data,
    input  logic             col2_valid,
    input  logic [ACC_W-1:0] col2_data,
    input  logic             result_ack,
    output logic [ACC_W-1:0] c11,
    output logic [ACC_W-1:0] c12,
    output logic [ACC_W-1:0] c21,
    output logic [ACC_W-1:0] c22,
    output logic             result_valid,
    output logic             busy,
    output logic             overflow
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       cnt1_q, cnt1_d;
    logic [1:0]       cnt2_q, cnt2_d;
    logic [ACC_W-1:0] c11_q, c11_d;
    logic [ACC_W-1:0] c12_q, c12_d;
    logic [ACC_W-1:0] c21_q, c21_d;
    logic [ACC_W-1:0] c22_q, c22_d;
    logic             result_valid_q, result_valid_d;
    logic             busy_q, busy_d;
    logic             overflow_q, overflow_d;

    logic             take1, take2, drop, clear;
    logic [1:0]       base1, base2;

    // Decide which words are accepted or dropped and route them into the next free slot
    always_comb begin
        take1 = 1'b0;
        take2 = 1'b0;
        drop  = 1'b0;
        clear = 1'b0;
        c11_d = c11_q;
        c12_d = c12_q;
        c21_d = c21_q;
        c22_d = c22_q;

        case (state_q)
            IDLE: begin
                take1 = col1_valid;
                take2 = col2_valid;
            end
            COLLECT: begin
                take1 = col1_valid && (cnt1_q != 2'd2);
                take2 = col2_valid && (cnt2_q != 2'd2);
                drop  = (col1_valid && (cnt1_q == 2'd2)) ||
                        (col2_valid && (cnt2_q == 2'd2));
            end
            DONE: begin
                if (result_ack) begin
                    // Accepted ack starts a fresh matrix; same-cycle words become slot 1
                    clear = 1'b1;
                    take1 = col1_valid;
                    take2 = col2_valid;
                end else begin
                    drop = col1_valid || col2_valid;
                end
            end
            default: begin
                take1 = 1'b0;
                take2 = 1'b0;
            end
        endcase

        if (clear) begin
            base1 = 2'd0;
            base2 = 2'd0;
        end else begin
            base1 = cnt1_q;
            base2 = cnt2_q;
        end

        if (take1) begin
            cnt1_d = base1 + 2'd1;
            if (base1 == 2'd0) begin
                c11_d = col1_data;
            end else begin
                c21_d = col1_data;
            end
        end else begin
            cnt1_d = base1;
        end

        if (take2) begin
            cnt2_d = base2 + 2'd1;
            if (base2 == 2'd0) begin
                c12_d = col2_data;
            end else begin
                c22_d = col2_data;
            end
        end else begin
            cnt2_d = base2;
        end

        if (clear) begin
            overflow_d = 1'b0;
        end else if (drop) begin
            overflow_d = 1'b1;
        end else begin
            overflow_d = overflow_q;
        end
    end

    // Next-state logic; status outputs are registered from the next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (take1 || take2) begin
                    state_d = COLLECT;
                end else begin
                    state_d = IDLE;
                end
            end
            COLLECT: begin
                if ((cnt1_d == 2'd2) && (cnt2_d == 2'd2)) begin
                    state_d = DONE;
                end else begin
                    state_d = COLLECT;
                end
            end
            DONE: begin
                if (clear) begin
                    if (take1 || take2) begin
                        state_d = COLLECT;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        result_valid_d = (state_d == DONE);
        busy_d         = (state_d == COLLECT);
    end

    // State, counters, matrix and status registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            cnt1_q         <= 2'd0;
            cnt2_q         <= 2'd0;
            c11_q          <= '0;
            c12_q          <= '0;
            c21_q          <= '0;
            c22_q          <= '0;
            result_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            overflow_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt1_q         <= cnt1_d;
            cnt2_q         <= cnt2_d;
            c11_q          <= c11_d;
            c12_q          <= c12_d;
            c21_q          <= c21_d;
            c22_q          <= c22_d;
            result_valid_q <= result_valid_d;
            busy_q         <= busy_d;
            overflow_q     <= overflow_d;
        end
    end

    assign c11          = c11_q;
    assign c12          = c12_q;
    assign c21          = c21_q;
    assign c22          = c22_q;
    assign result_valid = result_valid_q;
    assign busy         = busy_q;
    assign overflow     = overflow_q;

endmodule

// File: tb/tb_output_deskew.sv
// Self-checking bench for output_deskew: directed vector table for the listed scenarios,
// then randomized traffic checked against a queue-based reference model.
module tb_output_deskew;

    logic        clk;
    logic        reset;
    logic        col1_valid;
    logic [15:0] col1_data;
    logic        col2_valid;
    logic [15:0] col2_data;
    logic        result_ack;
    logic [15:0] c11, c12, c21, c22;
    logic        result_valid, busy, overflow;

    int checks   = 0;
    int failures = 0;

    output_deskew #(.ACC_W(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .col1_valid   (col1_valid),
        .col1_data    (col1_data),
        .col2_valid   (col2_valid),
        .col2_data    (col2_data),
        .result_ack   (result_ack),
        .c11          (c11),
        .c12          (c12),
        .c21          (c21),
        .c22          (c22),
        .result_valid (result_valid),
        .busy         (busy),
        .overflow     (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        v1;
        logic [15:0] d1;
        logic        v2;
        logic [15:0] d2;
        logic        ack;
        logic [15:0] e11;
        logic [15:0] e12;
        logic [15:0] e21;
        logic [15:0] e22;
        logic        erv;
        logic        ebusy;
        logic        eovf;
    } vec_t;

    vec_t tbl[$];

    // Reference model: words collected for the current matrix plus the visible registers
    logic [15:0] q1[$];
    logic [15:0] q2[$];
    logic [15:0] m11, m12, m21, m22;
    logic        m_ovf;

    task automatic add(input logic rst, input logic v1, input logic [15:0] d1,
                       input logic v2, input logic [15:0] d2, input logic ack,
                       input logic [15:0] e11, input logic [15:0] e12,
                       input logic [15:0] e21, input logic [15:0] e22,
                       input logic erv, input logic ebusy, input logic eovf);
        vec_t v;
        v.rst = rst; v.v1 = v1; v.d1 = d1; v.v2 = v2; v.d2 = d2; v.ack = ack;
        v.e11 = e11; v.e12 = e12; v.e21 = e21; v.e22 = e22;
        v.erv = erv; v.ebusy = ebusy; v.eovf = eovf;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input int cyc, input logic [15:0] act,
                       input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic v1, input logic [15:0] d1,
                         input logic v2, input logic [15:0] d2, input logic ack);
        @(negedge clk);
        reset      = rst;
        col1_valid = v1;
        col1_data  = d1;
        col2_valid = v2;
        col2_data  = d2;
        result_ack = ack;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input int cyc,
                             input logic [15:0] e11, input logic [15:0] e12,
                             input logic [15:0] e21, input logic [15:0] e22,
                             input logic erv, input logic ebusy, input logic eovf);
        chk({tag, "_c11"}, cyc, c11, e11);
        chk({tag, "_c12"}, cyc, c12, e12);
        chk({tag, "_c21"}, cyc, c21, e21);
        chk({tag, "_c22"}, cyc, c22, e22);
        chk({tag, "_result_valid"}, cyc, {15'd0, result_valid}, {15'd0, erv});
        chk({tag, "_busy"}, cyc, {15'd0, busy}, {15'd0, ebusy});
        chk({tag, "_overflow"}, cyc, {15'd0, overflow}, {15'd0, eovf});
    endtask

    task automatic model_push(input int col, input logic [15:0] d);
        if (col == 1) begin
            if (q1.size() == 0) m11 = d; else m21 = d;
            q1.push_back(d);
        end else begin
            if (q2.size() == 0) m12 = d; else m22 = d;
            q2.push_back(d);
        end
    endtask

    task automatic model_step(input logic rst, input logic v1, input logic [15:0] d1,
                              input logic v2, input logic [15:0] d2, input logic ack);
        bit complete;
        if (rst) begin
            q1.delete(); q2.delete();
            m11 = 16'd0; m12 = 16'd0; m21 = 16'd0; m22 = 16'd0;
            m_ovf = 1'b0;
        end else begin
            complete = (q1.size() == 2) && (q2.size() == 2);
            if (complete) begin
                if (ack) begin
                    q1.delete(); q2.delete();
                    m_ovf = 1'b0;
                    if (v1) model_push(1, d1);
                    if (v2) model_push(2, d2);
                end else if (v1 || v2) begin
                    m_ovf = 1'b1;
                end
            end else begin
                if (v1) begin
                    if (q1.size() == 2) m_ovf = 1'b1; else model_push(1, d1);
                end
                if (v2) begin
                    if (q2.size() == 2) m_ovf = 1'b1; else model_push(2, d2);
                end
            end
        end
    endtask

    initial begin
        logic m_done;
        logic m_busy;
        reset = 1'b1; col1_valid = 1'b0; col1_data = 16'd0;
        col2_valid = 1'b0; col2_data = 16'd0; result_ack = 1'b0;

        // Columns: rst v1 d1 v2 d2 ack | c11 c12 c21 c22 rv busy ovf
        add(1, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0);
        // standard skew
        add(0, 1, 16'h0013, 0, 16'h0000, 0, 16'h0013, 16'h0000, 16'h0000, 16'h0000, 0, 1, 0);
        add(0, 1, 16'h002B, 1, 16'h0016, 0, 16'h0013, 16'h0016, 16'h002B, 16'h0000, 0, 1, 0);
        add(0, 0, 16'h0000, 1, 16'h0032, 0, 16'h0013, 16'h0016, 16'h002B, 16'h0032, 1, 0, 0);
        add(0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0013, 16'h0016, 16'h002B, 16'h0032, 0, 0, 0);
        // aligned
        add(0, 1, 16'h0001, 1, 16'h0003, 0, 16'h0001, 16'h0003, 16'h002B, 16'h0032, 0, 1, 0);
        add(0, 1, 16'h0002, 1, 16'h0004, 0, 16'h0001, 16'h0003, 16'h0002, 16'h0004, 1, 0, 0);
        add(0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0001, 16'h0003, 16'h0002, 16'h0004, 0, 0, 0);
        // overflow: third col1 word dropped, then drop in DONE, ack clears
        add(0, 1, 16'h0005, 0, 16'h0000, 0, 16'h0005, 16'h0003, 16'h0002, 16'h0004, 0, 1, 0);
        add(0, 1, 16'h0006, 1, 16'h0008, 0, 16'h0005, 16'h0008, 16'h0006, 16'h0004, 0, 1, 0);
        add(0, 1, 16'h0007, 0, 16'h0000, 0, 16'h0005, 16'h0008, 16'h0006, 16'h0004, 0, 1, 1);
        add(0, 0, 16'h0000, 1, 16'h0009, 0, 16'h0005, 16'h0008, 16'h0006, 16'h0009, 1, 0, 1);
        add(0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0005, 16'h0008, 16'h0006, 16'h0009, 1, 0, 1);
        add(0, 1, 16'h0055, 0, 16'h0000, 0, 16'h0005, 16'h0008, 16'h0006, 16'h0009, 1, 0, 1);
        add(0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0005, 16'h0008, 16'h0006, 16'h0009, 0, 0, 0);
        // hold for 10 cycles, then ack + new word back-to-back
        add(0, 1, 16'h0011, 1, 16'h0012, 0, 16'h0011, 16'h0012, 16'h0006, 16'h0009, 0, 1, 0);
        add(0, 1, 16'h0021, 1, 16'h0022, 0, 16'h0011, 16'h0012, 16'h0021, 16'h0022, 1, 0, 0);
        for (int i = 0; i < 10; i++)
            add(0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0011, 16'h0012, 16'h0021, 16'h0022, 1, 0, 0);
        add(0, 1, 16'h00AA, 0, 16'h0000, 1, 16'h00AA, 16'h0012, 16'h0021, 16'h0022, 0, 1, 0);
        add(0, 0, 16'h0000, 1, 16'h00CC, 0, 16'h00AA, 16'h00CC, 16'h0021, 16'h0022, 0, 1, 0);
        // reset mid-collection has priority over a valid word
        add(1, 1, 16'h0077, 0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0);
        add(0, 1, 16'h0041, 0, 16'h0000, 0, 16'h0041, 16'h0000, 16'h0000, 16'h0000, 0, 1, 0);
        add(0, 1, 16'h0042, 1, 16'h0043, 0, 16'h0041, 16'h0043, 16'h0042, 16'h0000, 0, 1, 0);
        add(0, 0, 16'h0000, 1, 16'h0044, 0, 16'h0041, 16'h0043, 16'h0042, 16'h0044, 1, 0, 0);
        add(0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0041, 16'h0043, 16'h0042, 16'h0044, 0, 0, 0);
        // ack while collecting or idle is ignored
        add(0, 1, 16'h0061, 0, 16'h0000, 1, 16'h0061, 16'h0043, 16'h0042, 16'h0044, 0, 1, 0);
        add(0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0061, 16'h0043, 16'h0042, 16'h0044, 0, 1, 0);
        add(0, 1, 16'h0062, 1, 16'h0063, 1, 16'h0061, 16'h0063, 16'h0062, 16'h0044, 0, 1, 0);
        add(0, 0, 16'h0000, 1, 16'h0064, 0, 16'h0061, 16'h0063, 16'h0062, 16'h0064, 1, 0, 0);
        add(0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0061, 16'h0063, 16'h0062, 16'h0064, 0, 0, 0);
        add(0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0061, 16'h0063, 16'h0062, 16'h0064, 0, 0, 0);

        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].v1, tbl[i].d1, tbl[i].v2, tbl[i].d2, tbl[i].ack);
            check_all("vec", i, tbl[i].e11, tbl[i].e12, tbl[i].e21, tbl[i].e22,
                      tbl[i].erv, tbl[i].ebusy, tbl[i].eovf);
        end

        // randomized traffic against the reference model
        drive(1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
        model_step(1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
        for (int c = 0; c < 3000; c++) begin
            logic        r_rst, r_v1, r_v2, r_ack;
            logic [15:0] r_d1, r_d2;
            r_rst = ($urandom_range(0, 99) == 0);
            r_v1  = ($urandom_range(0, 99) < 55);
            r_v2  = ($urandom_range(0, 99) < 55);
            r_ack = ($urandom_range(0, 99) < 30);
            r_d1  = 16'($urandom);
            r_d2  = 16'($urandom);
            drive(r_rst, r_v1, r_d1, r_v2, r_d2, r_ack);
            model_step(r_rst, r_v1, r_d1, r_v2, r_d2, r_ack);
            m_done = (q1.size() == 2) && (q2.size() == 2);
            m_busy = ((q1.size() + q2.size()) > 0) && !m_done;
            check_all("rand", c, m11, m12, m21, m22, m_done, m_busy, m_ovf);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
